// File: rtl/tl_xbar_pkg.sv
// Shared TileLink-UL types, opcode constants and FSM states for the
// single-owner round-robin crossbar.
package tl_xbar_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic [5:0]  d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;
  } tl_d_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } xbar_state_e;

endpackage

// File: rtl/tl_xbar_rr_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   k;
  logic found;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the logic leaves it unassigned, which would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/tl_xbar_rr.sv
// Single-owner TileLink-UL crossbar: round-robin master arbitration, table
// decode, internal denied responses for unmapped targets and stuck slaves.
module tl_xbar_rr
  import tl_xbar_pkg::*;
#(
  parameter int                     NM       = 4,
  parameter int                     NS       = 8,
  parameter logic [NS-1:0][63:0]    SLV_BASE = '0,
  parameter logic [NS-1:0][63:0]    SLV_MASK = '0,
  parameter int                     TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NM-1:0]         m_a_valid,
  output logic [NM-1:0]         m_a_ready,
  input  tl_a_t [NM-1:0]        m_a_bits,
  output logic [NM-1:0]         m_d_valid,
  input  logic [NM-1:0]         m_d_ready,
  output tl_d_t [NM-1:0]        m_d_bits,
  output logic [NS-1:0]         s_a_valid,
  input  logic [NS-1:0]         s_a_ready,
  output tl_a_t [NS-1:0]        s_a_bits,
  input  logic [NS-1:0]         s_d_valid,
  output logic [NS-1:0]         s_d_ready,
  input  tl_d_t [NS-1:0]        s_d_bits,
  output logic [NM-1:0]         grant,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int MW = $clog2(NM);
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  xbar_state_e   state, state_d;
  logic [MW-1:0] rr_ptr, owner, arb_idx, ptr_next;
  logic [SW-1:0] tgt, dec_idx;
  logic          unmapped, dec_hit, done;
  logic [2:0]    lat_opcode, lat_size;
  logic [3:0]    lat_source;
  logic [CW-1:0] cnt;
  logic [NM-1:0] arb_grant;
  logic [63:0]   win_addr;
  tl_a_t         a_fwd;
  tl_d_t         d_err;

  rr_arbiter #(.N(NM), .IW(MW)) u_arb (
    .req   (m_a_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Scan downward so the lowest matching slave index is the one left standing.
  assign win_addr = m_a_bits[arb_idx].a_address;
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int j = NS - 1; j >= 0; j--) begin
      if ((win_addr & ~SLV_MASK[j]) == SLV_BASE[j]) begin
        dec_hit = 1'b1;
        dec_idx = SW'(j);
      end
    end
  end

  assign ptr_next = (owner == MW'(NM - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    a_fwd           = m_a_bits[owner];
    a_fwd.a_address = m_a_bits[owner].a_address & SLV_MASK[tgt];

    d_err           = '0;
    d_err.d_opcode  = (lat_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    d_err.d_denied  = 1'b1;
    d_err.d_corrupt = (lat_opcode == A_GET);
    d_err.d_size    = lat_size;
    d_err.d_source  = lat_source;
  end

  always_comb begin
    state_d     = state;
    done        = 1'b0;
    m_a_ready   = '0;
    m_d_valid   = '0;
    m_d_bits    = '0;
    s_a_valid   = '0;
    s_a_bits    = '0;
    s_d_ready   = '1;   // stray or late D beats are sunk everywhere but the live target
    err_timeout = 1'b0;
    busy        = (state != ST_IDLE);
    grant       = busy ? (NM'(1) << owner) : '0;

    unique case (state)
      ST_IDLE: begin
        if (|m_a_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (unmapped) begin
          m_a_ready[owner] = 1'b1;
          state_d          = ST_ERR;
        end else begin
          s_a_valid[tgt]   = m_a_valid[owner];
          s_a_bits[tgt]    = a_fwd;
          m_a_ready[owner] = s_a_ready[tgt];
          if (m_a_valid[owner] && s_a_ready[tgt]) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        m_d_valid[owner] = s_d_valid[tgt];
        m_d_bits[owner]  = s_d_bits[tgt];
        s_d_ready[tgt]   = m_d_ready[owner];
        if (s_d_valid[tgt] && m_d_ready[owner]) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          err_timeout = 1'b1;
          state_d     = ST_ERR;
        end
      end
      ST_ERR: begin
        m_d_valid[owner] = 1'b1;
        m_d_bits[owner]  = d_err;
        if (m_d_ready[owner]) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset is sampled synchronously, but outputs are held quiet while it is asserted.
    if (!rst_n) begin
      m_a_ready   = '0;
      m_d_valid   = '0;
      m_d_bits    = '0;
      s_a_valid   = '0;
      s_a_bits    = '0;
      s_d_ready   = '0;
      err_timeout = 1'b0;
      busy        = 1'b0;
      grant       = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset here is synchronous, checked only at clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      tgt        <= '0;
      unmapped   <= 1'b0;
      lat_opcode <= '0;
      lat_size   <= '0;
      lat_source <= '0;
      cnt        <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && |m_a_valid) begin
        owner      <= arb_idx;
        tgt        <= dec_idx;
        unmapped   <= !dec_hit;
        lat_opcode <= m_a_bits[arb_idx].a_opcode;
        lat_size   <= m_a_bits[arb_idx].a_size;
        lat_source <= m_a_bits[arb_idx].a_source;
      end
      if (state == ST_REQ)       cnt <= '0;
      else if (state == ST_RESP) cnt <= cnt + 1'b1;
      if (done) rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_tl_xbar_rr.sv
// Directed bench for tl_xbar_rr: table of single transactions plus
// hand-written round-robin, reset, watchdog and backpressure sequences.
module tb_tl_xbar_rr;
  import tl_xbar_pkg::*;

  localparam int NM = 4;
  localparam int NS = 4;
  localparam logic [NS-1:0][63:0] BASE = {64'h3000_0000, 64'h1000_0000, 64'h2000_0000, 64'h0};
  localparam logic [NS-1:0][63:0] MASK = {64'hFF, 64'hFFF, 64'hFFFF, 64'hFFFF};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] m_a_valid, m_a_ready, m_d_valid, m_d_ready, grant;
  tl_a_t [NM-1:0] m_a_bits;
  tl_d_t [NM-1:0] m_d_bits;
  logic [NS-1:0] s_a_valid, s_a_ready, s_d_valid, s_d_ready;
  tl_a_t [NS-1:0] s_a_bits;
  tl_d_t [NS-1:0] s_d_bits;
  logic          busy, err_timeout;

  int n_checks = 0;
  int n_err    = 0;
  int a_hs     = 0;
  int d_hs     = 0;

  tl_xbar_rr #(
    .NM(NM), .NS(NS), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_bits(m_a_bits),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_bits(m_d_bits),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_bits(s_a_bits),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_bits(s_d_bits),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_a_valid[2] && s_a_ready[2]) a_hs++;
    if (m_d_valid[3] && m_d_ready[3]) d_hs++;
  end

  typedef struct {
    int          m;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [3:0]  src;
    logic [2:0]  size;
    logic [63:0] rsp_data;
    int          slv;      // -1 = unmapped
    logic [63:0] off;
    logic [2:0]  d_op;
    logic        denied;
    logic        corrupt;
    logic [63:0] d_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NM-1:0] oh(input int i);
    logic [NM-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic tl_a_t mk_a(input logic [2:0] op, input logic [63:0] addr,
                                 input logic [3:0] src, input logic [2:0] size,
                                 input logic [63:0] data);
    tl_a_t a;
    a = '0;
    a.a_opcode  = op;
    a.a_size    = size;
    a.a_source  = src;
    a.a_address = addr;
    a.a_mask    = 8'hFF;
    a.a_data    = data;
    return a;
  endfunction

  task automatic clear_inputs();
    m_a_valid = '0; m_a_bits = '0; m_d_ready = '0;
    s_a_ready = '0; s_d_valid = '0; s_d_bits = '0;
  endtask

  task automatic run_vec(input vec_t v);
    tl_d_t rsp;
    @(negedge clk);
    m_a_bits[v.m]  = mk_a(v.op, v.addr, v.src, v.size, 64'h5A5A);
    m_a_valid[v.m] = 1'b1;
    #1 check("idle_a_ready", m_a_ready, '0);
    @(negedge clk);
    check("req_grant", grant, oh(v.m));
    if (v.slv < 0) begin
      #1;
      check("unmapped_accept", m_a_ready, oh(v.m));
      check("unmapped_no_s_a", s_a_valid, '0);
    end else begin
      check("s_a_valid", s_a_valid, 4'(oh(v.slv)));
      check("s_a_offset", s_a_bits[v.slv].a_address, v.off);
      s_a_ready[v.slv] = 1'b1;
      #1 check("a_ready_pass", m_a_ready, oh(v.m));
    end
    @(negedge clk);
    m_a_valid = '0;
    s_a_ready = '0;
    m_d_ready[v.m] = 1'b1;
    if (v.slv >= 0) begin
      rsp = '0;
      rsp.d_opcode = (v.op == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      rsp.d_source = v.src;
      rsp.d_size   = v.size;
      rsp.d_data   = v.rsp_data;
      s_d_bits[v.slv]  = rsp;
      s_d_valid[v.slv] = 1'b1;
    end
    #1;
    check("d_valid", m_d_valid, oh(v.m));
    check("d_opcode", m_d_bits[v.m].d_opcode, v.d_op);
    check("d_denied", m_d_bits[v.m].d_denied, v.denied);
    check("d_corrupt", m_d_bits[v.m].d_corrupt, v.corrupt);
    check("d_data", m_d_bits[v.m].d_data, v.d_data);
    check("d_source", m_d_bits[v.m].d_source, v.src);
    check("d_size", m_d_bits[v.m].d_size, v.size);
    @(negedge clk);
    clear_inputs();
    #1 check("txn_done_idle", busy, 1'b0);
  endtask

  initial begin : main
    int          order[6];
    int          n_got;
    int          first;
    int          a0, d0;
    logic [NM-1:0] prev;
    tl_d_t       rsp;

    vecs[0] = '{0, A_GET,         64'h1000_0123, 4'd5,  3'd2, 64'hDEAD, 2,  64'h123,  3'd1, 1'b0, 1'b0, 64'hDEAD};
    vecs[1] = '{1, A_PUT_FULL,    64'hF000_0000, 4'd3,  3'd3, 64'h0,    -1, 64'h0,    3'd0, 1'b1, 1'b0, 64'h0};
    vecs[2] = '{1, A_GET,         64'hF000_0000, 4'd9,  3'd3, 64'h0,    -1, 64'h0,    3'd1, 1'b1, 1'b1, 64'h0};
    vecs[3] = '{2, A_PUT_PARTIAL, 64'h2000_ABCD, 4'd1,  3'd0, 64'h0,    1,  64'hABCD, 3'd0, 1'b0, 1'b0, 64'h0};
    vecs[4] = '{3, A_GET,         64'h3000_00FF, 4'd15, 3'd1, 64'h77,   3,  64'hFF,   3'd1, 1'b0, 1'b0, 64'h77};
    vecs[5] = '{0, A_GET,         64'h3000_0100, 4'd7,  3'd3, 64'h0,    -1, 64'h0,    3'd1, 1'b1, 1'b1, 64'h0};
    vecs[6] = '{2, A_GET,         64'h0000_FFFF, 4'd2,  3'd3, 64'h1234, 0,  64'hFFFF, 3'd1, 1'b0, 1'b0, 64'h1234};

    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_s_d_ready", s_d_ready, '0);
    check("rst_m_a_ready", m_a_ready, '0);
    check("rst_err", err_timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_stray_sink", s_d_ready, 4'hF);

    // Round-robin among masters 0, 1, 3 with instant slaves
    for (int i = 0; i < NM; i++) m_a_bits[i] = mk_a(A_PUT_FULL, 64'h40, 4'(i), 3'd3, 64'h1);
    s_a_ready = '1; s_d_valid = '1; m_d_ready = '1;
    m_a_valid = 4'b1011;
    n_got = 0;
    prev  = '0;
    for (int c = 0; c < 40 && n_got < 6; c++) begin
      @(negedge clk);
      #1;
      if (grant != '0 && prev == '0) begin
        order[n_got] = (grant == 4'b0001) ? 0 : (grant == 4'b0010) ? 1 :
                       (grant == 4'b0100) ? 2 : (grant == 4'b1000) ? 3 : 9;
        n_got++;
      end
      prev = grant;
    end
    @(negedge clk);
    m_a_valid = '0;
    @(negedge clk);
    clear_inputs();
    check("rr_count", n_got, 6);
    check("rr_0", order[0], 0);
    check("rr_1", order[1], 1);
    check("rr_2", order[2], 3);
    check("rr_3", order[3], 0);
    check("rr_4", order[4], 1);
    check("rr_5", order[5], 3);

    // Table of single transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset mid-RESP; rr pointer (3 here) must return to 0
    @(negedge clk);
    m_a_bits[3] = mk_a(A_GET, 64'h100, 4'd4, 3'd3, 64'h0);
    m_a_valid[3] = 1'b1;
    s_a_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_a_valid = '0; s_a_ready = '0;
    #1 check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_grant", grant, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_s_a_valid", s_a_valid, '0);
    check("mid_rst_m_d_valid", m_d_valid, '0);
    m_a_bits[2] = mk_a(A_GET, 64'h200, 4'd8, 3'd3, 64'h0);
    m_a_bits[3] = mk_a(A_GET, 64'h200, 4'd9, 3'd3, 64'h0);
    m_a_valid = 4'b1100;
    @(negedge clk);
    check("post_rst_grant", grant, 4'b0100);
    m_a_valid[3] = 1'b0;
    s_a_ready[0] = 1'b1;
    @(negedge clk);
    m_a_valid = '0; s_a_ready = '0;
    rsp = '0; rsp.d_opcode = D_ACCESS_ACK_DATA; rsp.d_source = 4'd8; rsp.d_size = 3'd3;
    s_d_bits[0] = rsp; s_d_valid[0] = 1'b1; m_d_ready[2] = 1'b1;
    #1 check("post_rst_d_valid", m_d_valid, 4'b0100);
    @(negedge clk);
    clear_inputs();
    #1 check("post_rst_idle", busy, 1'b0);

    // Watchdog: slave 1 never answers
    @(negedge clk);
    m_a_bits[0] = mk_a(A_GET, 64'h2000_0010, 4'd6, 3'd3, 64'h0);
    m_a_valid[0] = 1'b1;
    s_a_ready[1] = 1'b1;
    @(negedge clk);
    #1 check("wd_a_hs", m_a_ready, 4'b0001);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(negedge clk);
      m_a_valid = '0; s_a_ready = '0;
      #1;
      if (err_timeout) first = k;
      else if (m_d_valid != '0) check("wd_early_d", m_d_valid, '0);
    end
    check("wd_expiry_cycle", first, 8);
    @(negedge clk);
    m_d_ready[0] = 1'b1;
    #1;
    check("wd_pulse_once", err_timeout, 1'b0);
    check("wd_d_valid", m_d_valid, 4'b0001);
    check("wd_d_opcode", m_d_bits[0].d_opcode, D_ACCESS_ACK_DATA);
    check("wd_d_denied", m_d_bits[0].d_denied, 1'b1);
    check("wd_d_corrupt", m_d_bits[0].d_corrupt, 1'b1);
    check("wd_d_data", m_d_bits[0].d_data, 64'h0);
    check("wd_d_source", m_d_bits[0].d_source, 4'd6);
    @(negedge clk);
    m_d_ready = '0;
    rsp = '0; rsp.d_opcode = D_ACCESS_ACK_DATA; rsp.d_data = 64'hBEEF; rsp.d_source = 4'd6;
    s_d_bits[1] = rsp; s_d_valid[1] = 1'b1;
    #1;
    check("late_d_sunk", s_d_ready[1], 1'b1);
    check("late_d_blocked", m_d_valid, '0);
    check("late_d_idle", busy, 1'b0);
    @(negedge clk);
    clear_inputs();

    // Backpressure on both channels
    a0 = a_hs; d0 = d_hs;
    @(negedge clk);
    m_a_bits[3] = mk_a(A_PUT_FULL, 64'h1000_0456, 4'd2, 3'd3, 64'hABCD);
    m_a_valid[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_s_a_valid", s_a_valid, 4'b0100);
      check("bp_s_a_addr", s_a_bits[2].a_address, 64'h456);
      check("bp_s_a_data", s_a_bits[2].a_data, 64'hABCD);
      check("bp_m_a_ready", m_a_ready, '0);
    end
    @(negedge clk);
    s_a_ready[2] = 1'b1;
    #1 check("bp_a_accept", m_a_ready, 4'b1000);
    @(negedge clk);
    m_a_valid = '0; s_a_ready = '0;
    rsp = '0; rsp.d_opcode = D_ACCESS_ACK; rsp.d_source = 4'd2; rsp.d_size = 3'd3;
    s_d_bits[2] = rsp; s_d_valid[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("bp_d_held", m_d_valid, 4'b1000);
      check("bp_s_d_ready", s_d_ready[2], 1'b0);
    end
    @(negedge clk);
    m_d_ready[3] = 1'b1;
    #1 check("bp_d_source", m_d_bits[3].d_source, 4'd2);
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    check("bp_a_once", a_hs - a0, 1);
    check("bp_d_once", d_hs - d0, 1);
    check("bp_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
